oam_dma: RTL and testbench

- OAM DMA controller. A CPU write to register 0xFF46 (decoded at top level) starts a copy of 160 bytes from source page XX00–XX9F into OAM at 0xFE00–0xFE9F.
- While copying, it owns the system bus for reads and drives the OAM write port.
- `active` tells the top-level bus multiplexer to steer the bus to the DMA source address and to restrict the CPU to High RAM.
- Pacing is one byte per M-cycle (4 clocks at 4 MHz).

---
 rtl/oam_dma.sv | 139 +++++++++++++
 tb/tb_oam_dma.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA controller: copies NUM_BYTES bytes from page {src,00} into OAM,
// one byte per CYCLES_PER_BYTE clocks, after a START_DELAY clock lead-in.
// Handshake: there is no backpressure. dma_read is a one-clock request and
// the source returns data on dma_data_in exactly one clock later. oam_write is
// a one-clock strobe qualified by oam_addr/oam_data_out in the same clock.
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int NUM_BYTES       = 160,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_write,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  output logic        active,
  output logic [15:0] dma_addr,
  output logic        dma_read,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTING = 2'd1,
    TRANSFER = 2'd2
  } state_e;

  localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = $clog2(START_DELAY + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PH_CAPT  = PW'(1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_BYTES - 1);

  state_e         state_q, state_d;
  logic [7:0]     src_q, src_d;
  logic [7:0]     index_q, index_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [DW-1:0]  delay_q, delay_d;
  logic           keep_q, keep_d;   // restart issued while bus was owned
  logic [7:0]     data_q, data_d;
  logic [7:0]     src_map;

  // E0-FF is an echo of WRAM, so the source page folds down onto C0-DF.
  assign src_map = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;

  // Output decode: strobes only exist inside TRANSFER.
  always_comb begin
    active       = (state_q == TRANSFER) || ((state_q == STARTING) && keep_q);
    dma_read     = (state_q == TRANSFER) && (phase_q == '0);
    oam_write    = (state_q == TRANSFER) && (phase_q == PH_LAST);
    dma_addr     = (state_q == TRANSFER) ? {src_map, index_q} : 16'h0000;
    oam_addr     = (state_q == TRANSFER) ? index_q : 8'h00;
    oam_data_out = data_q;
    reg_data_out = src_q;
    dbg_state    = state_q;
  end

  // Next-state logic; a register write overrides whatever is in flight.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    index_d = index_q;
    phase_d = phase_q;
    delay_d = delay_q;
    keep_d  = keep_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        keep_d = 1'b0;
      end
      STARTING: begin
        if (delay_q == DLY_LAST) begin
          state_d = TRANSFER;
          phase_d = '0;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      TRANSFER: begin
        if (phase_q == PH_CAPT) begin
          data_d = dma_data_in;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (index_q == IDX_LAST) begin
            state_d = IDLE;
            index_d = 8'h00;
            keep_d  = 1'b0;
          end else begin
            index_d = index_q + 8'h01;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reg_write) begin
      src_d   = reg_data_in;
      index_d = 8'h00;
      delay_d = '0;
      phase_d = '0;
      keep_d  = active;
      state_d = STARTING;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= 8'hFF;
      index_q <= 8'h00;
      phase_q <= '0;
      delay_q <= '0;
      keep_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      index_q <= index_d;
      phase_q <= phase_d;
      delay_q <= delay_d;
      keep_q  <= keep_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: arithmetic timing model keyed on the cycle of the last
// register write, plus an expected queue of OAM writes.
module tb_oam_dma;

  localparam int SD   = 4;
  localparam int CPB  = 4;
  localparam int NB   = 160;
  localparam int LAST = SD + CPB * NB;   // t of the final OAM write

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_write = 1'b0;
  logic [7:0]  reg_data_in = 8'h00;
  logic [7:0]  reg_data_out;
  logic        active;
  logic [15:0] dma_addr;
  logic        dma_read;
  logic [7:0]  dma_data_in = 8'h00;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data_out;
  logic [1:0]  dbg_state;

  oam_dma #(.CYCLES_PER_BYTE(CPB), .NUM_BYTES(NB), .START_DELAY(SD)) dut (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
    .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
    .active(active), .dma_addr(dma_addr), .dma_read(dma_read),
    .dma_data_in(dma_data_in), .oam_addr(oam_addr), .oam_write(oam_write),
    .oam_data_out(oam_data_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- source memory model ----------------
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] + 8'h40;
    return a[7:0] ^ 8'h5A ^ hi;
  endfunction

  // Synchronous read: data appears the clock after the request; junk otherwise.
  always @(posedge clk) begin
    if (dma_read) dma_data_in <= mem_f(dma_addr);
    else          dma_data_in <= 8'($urandom);
  end

  // ---------------- reference model ----------------
  bit         cur_valid = 0;
  int         cur_k = 0;
  logic [7:0] cur_s = 8'h00;
  bit         cur_keep = 0;
  bit         pend_valid = 0;
  int         pend_k = 0;
  logic [7:0] pend_s = 8'h00;
  bit         pend_keep = 0;
  logic [7:0] exp_rdo = 8'hFF;
  logic [15:0] exp_q[$];
  int         wr_cnt = 0;

  function automatic logic [7:0] map_src(input logic [7:0] s);
    return (s >= 8'hE0) ? (s & 8'hDF) : s;
  endfunction

  function automatic bit m_active(input int c);
    int t;
    if (!cur_valid) return 1'b0;
    t = c - cur_k;
    return ((t >= SD + 1) && (t <= LAST)) || ((t >= 1) && (t <= SD) && cur_keep);
  endfunction

  // A write issued in cycle k takes effect from cycle k+1.
  task automatic promote();
    if (pend_valid && pend_k < cyc) begin
      cur_valid  = 1;
      cur_k      = pend_k;
      cur_s      = pend_s;
      cur_keep   = pend_keep;
      exp_rdo    = pend_s;
      pend_valid = 0;
      exp_q.delete();
    end
  endtask

  task automatic model_reset();
    cur_valid  = 0;
    pend_valid = 0;
    exp_rdo    = 8'hFF;
    exp_q.delete();
  endtask

  logic [7:0]  m_sp;
  logic [7:0]  m_idx;
  logic [15:0] m_ent;
  int          m_t;
  bit          e_act, e_rd, e_wr;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    promote();
    m_t   = cyc - cur_k;
    e_act = m_active(cyc);
    e_rd  = cur_valid && (m_t >= SD + 1) && (m_t <= LAST) && ((m_t - SD - 1) % CPB == 0);
    e_wr  = cur_valid && (m_t >= SD + CPB) && (m_t <= LAST) && ((m_t - SD - CPB) % CPB == 0);
    check_eq("active", active, e_act);
    check_eq("dma_read", dma_read, e_rd);
    check_eq("oam_write", oam_write, e_wr);
    check_eq("reg_data_out", reg_data_out, exp_rdo);
    if (dma_read) check_eq("addr_below_e000", dma_addr < 16'hE000, 1);
    if (oam_write) wr_cnt++;
    if (e_rd) begin
      m_sp  = map_src(cur_s);
      m_idx = 8'((m_t - SD - 1) / CPB);
      check_eq("dma_addr", dma_addr, {m_sp, m_idx});
      exp_q.push_back({m_idx, mem_f({m_sp, m_idx})});
    end
    if (e_wr) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty", 0, 1);
      end else begin
        m_ent = exp_q.pop_front();
        check_eq("oam_addr", oam_addr, m_ent[15:8]);
        check_eq("oam_data", oam_data_out, m_ent[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  // Called at #1 after a posedge; reg_write is high for exactly this cycle.
  task automatic start_xfer(input logic [7:0] s, output int k);
    promote();
    k           = cyc;
    reg_write   = 1'b1;
    reg_data_in = s;
    pend_keep   = m_active(k);
    pend_k      = k;
    pend_s      = s;
    pend_valid  = 1;
    tick(1);
    reg_write   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int k1, k2, wr_before;
  logic [7:0] rs;

  initial begin
    // reset hold and release, then idle observation
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check_eq("idle_writes", wr_cnt, 0);

    // basic copy from C000
    wr_cnt = 0;
    start_xfer(8'hC0, k1);
    wait_until(k1 + LAST + 10);
    check_eq("basic_count", wr_cnt, NB);
    check_eq("basic_rdo", reg_data_out, 8'hC0);

    // mirrored page F1 -> D1
    wr_cnt = 0;
    start_xfer(8'hF1, k1);
    wait_until(k1 + LAST + 10);
    check_eq("mirror_count", wr_cnt, NB);

    // restart at byte 50, phase 2
    start_xfer(8'h80, k1);
    wait_until(k1 + SD + 1 + CPB * 50 + 2);
    wr_cnt = 0;
    start_xfer(8'hC0, k2);
    wait_until(k2 + LAST + 10);
    check_eq("restart_count", wr_cnt, NB);

    // back-to-back: rewrite coincident with the final write
    wr_cnt = 0;
    start_xfer(8'hC3, k1);
    wait_until(k1 + LAST);
    start_xfer(8'hE5, k2);
    wait_until(k2 + LAST + 10);
    check_eq("b2b_count", wr_cnt, 2 * NB);

    // randomized pages and restart points
    for (int i = 0; i < 5; i++) begin
      rs = 8'($urandom_range(0, 255));
      start_xfer(rs, k1);
      tick($urandom_range(2, LAST + 20));
    end
    tick(LAST + 10);

    // asynchronous reset in the middle of byte 100's read cycle
    start_xfer(8'hC0, k1);
    wait_until(k1 + SD + 1 + CPB * 100);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_active", active, 0);
    check_eq("rst_dma_read", dma_read, 0);
    check_eq("rst_oam_write", oam_write, 0);
    check_eq("rst_oam_addr", oam_addr, 0);
    check_eq("rst_dma_addr", dma_addr, 0);
    check_eq("rst_rdo", reg_data_out, 8'hFF);
    tick(2);
    reset_n = 1'b1;
    wr_before = wr_cnt;
    tick(40);
    check_eq("post_rst_writes", wr_cnt - wr_before, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
